stream_mux4_rr: RTL and testbench

//   Merges four valid/ready input streams into one output stream. It is the

---
 rtl/stream_mux4_rr.sv | 101 ++++++++++
 tb/tb_stream_mux4_rr.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux4_rr.sv
// stream_mux4_rr: merges four valid/ready input streams into one registered
// output stream. Channel choice is either a fixed index (mode=0) or
// round-robin fair arbitration (mode=1). A one-entry output buffer gives
// one beat per clock at 1-cycle latency, with drain and reload on the same
// edge.
module stream_mux4_rr #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [1:0]      sel,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_sel,
  input  logic            out_ready
);

  // Output buffer and arbitration state
  logic          out_valid_reg;
  logic [DW-1:0] out_data_reg;
  logic [1:0]    out_sel_reg;
  logic [1:0]    rr_ptr_reg;

  // Arbitration signals
  logic          load_en;
  logic [3:0]    grant;
  logic [1:0]    grant_idx;
  logic          xfer;
  logic          rr_found;
  logic [1:0]    rr_idx;

  // Per-channel view of the packed data bus
  logic [DW-1:0] ch_data [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      assign ch_data[gi] = in_data[gi*DW +: DW];
    end
  endgenerate

  // The buffer can take a new beat when it is empty or being drained now
  assign load_en = !out_valid_reg | out_ready;

  // Pick the single eligible channel: fixed index, or first valid from rr_ptr
  always_comb begin
    grant    = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    if (!mode) begin
      if (in_valid[sel]) grant[sel] = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        rr_idx = rr_ptr_reg + 2'(i);
        if (!rr_found && in_valid[rr_idx]) begin
          grant[rr_idx] = 1'b1;
          rr_found      = 1'b1;
        end
      end
    end
  end

  // Encode the one-hot grant into a channel index
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) grant_idx = 2'(i);
    end
  end

  // Ready only goes to the granted channel, never during reset or a stall
  assign in_ready = grant & {4{load_en & ~rst}};
  assign xfer     = |in_ready;

  // Output buffer load/drain and round-robin pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else if (load_en) begin
      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= ch_data[grant_idx];
        out_sel_reg   <= grant_idx;
        if (mode) rr_ptr_reg <= grant_idx + 2'd1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_stream_mux4_rr.sv
// tb_stream_mux4_rr: directed scenarios plus a randomized run, all compared
// against a small behavioural model of the merge (buffer + pointer) and a
// FIFO scoreboard of accepted beats.
module tb_stream_mux4_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int         m_ptr   = 0;
  bit         m_valid = 0;
  logic [7:0] m_data  = '0;
  int         m_sel   = 0;

  always #5 clk = ~clk;

  stream_mux4_rr #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  // Channel the model would accept from this cycle, or -1 for none
  function automatic int model_pick();
    int pick = -1;
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    if (!mode) begin
      if (in_valid[sel]) pick = int'(sel);
    end else begin
      for (int off = 0; off < 4; off++) begin
        int c = (m_ptr + off) % 4;
        if (pick < 0 && in_valid[c]) pick = c;
      end
    end
    return pick;
  endfunction

  function automatic logic [3:0] model_ready();
    logic [3:0] r = '0;
    int p = model_pick();
    if (p >= 0) r[p] = 1'b1;
    return r;
  endfunction

  // Advance one clock: compute the model's next state from the pre-edge
  // inputs, take the edge, then commit it and step away from the edge.
  task automatic advance();
    int         p     = model_pick();
    int         n_ptr = m_ptr;
    bit         n_val = m_valid;
    logic [7:0] n_dat = m_data;
    int         n_sel = m_sel;
    if (rst) begin
      n_ptr = 0; n_val = 0; n_dat = '0; n_sel = 0;
    end else if (!m_valid || out_ready) begin
      if (p >= 0) begin
        n_val = 1;
        n_dat = in_data[p*8 +: 8];
        n_sel = p;
        if (mode) n_ptr = (p + 1) % 4;
      end else begin
        n_val = 0;
      end
    end
    @(posedge clk);
    m_ptr = n_ptr; m_valid = n_val; m_data = n_dat; m_sel = n_sel;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; mode = 0; sel = 0; in_valid = 4'b1111;
    in_data = $urandom; out_ready = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_in_ready cycle %0d: got %b want 0000", c, in_ready);
      end
      advance();
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%0d want v=0 d=00 s=0",
               out_valid, out_data, out_sel);
    end
    $display("test_reset: out_valid=%b out_data=%h out_sel=%0d", out_valid, out_data, out_sel);
    rst = 0;
  endtask

  task automatic test_fixed();
    mode = 0; sel = 2; in_valid = 4'b1111; out_ready = 1;
    in_data = $urandom;
    in_data[23:16] = 8'hA5;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL fixed_in_ready: got %b want 0100", in_ready);
    end
    advance();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL fixed_beat: got v=%b d=%h s=%0d want v=1 d=a5 s=2",
               out_valid, out_data, out_sel);
    end
    $display("test_fixed: out_data=%h out_sel=%0d", out_data, out_sel);
  endtask

  // Pointer was untouched by fixed mode, so the sequence must start at ch0
  task automatic test_round_robin();
    mode = 1; in_valid = 4'b1111; out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = $urandom;
      #1;
      n_checks++;
      if (in_ready !== model_ready()) begin
        n_fail++;
        $display("FAIL rr_in_ready beat %0d: got %b want %b", i, in_ready, model_ready());
      end
      advance();
      n_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== m_data) begin
        n_fail++;
        $display("FAIL rr_beat %0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 i, out_valid, out_sel, out_data, i % 4, m_data);
      end
      $display("test_round_robin: beat %0d out_sel=%0d out_data=%h", i, out_sel, out_data);
    end
  endtask

  task automatic test_backpressure();
    int delivered = 0;
    mode = 0; sel = 1; in_valid = 4'b0010; out_ready = 1;
    in_data = $urandom;
    in_data[15:8] = 8'h3C;
    #1;
    advance();
    out_ready = 0; in_valid = 4'b1111; in_data = $urandom;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 2'd1) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got r=%b v=%b d=%h s=%0d want r=0000 v=1 d=3c s=1",
                 c, in_ready, out_valid, out_data, out_sel);
      end
      advance();
    end
    out_ready = 1; in_valid = 4'b0000;
    #1;
    if (out_valid && out_ready) delivered++;
    advance();
    if (out_valid && out_ready) delivered++;
    n_checks++;
    if (delivered !== 1) begin
      n_fail++;
      $display("FAIL stall_deliver_once: got %0d deliveries want 1", delivered);
    end
    $display("test_backpressure: 3c delivered %0d time(s)", delivered);
  endtask

  task automatic test_sparse_rr();
    mode = 1; out_ready = 1; in_data = $urandom;
    in_valid = 4'b0010;                      // ch1 -> pointer moves to 2
    #1;
    advance();
    in_valid = 4'b0001;
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL sparse_ch0: got %b want 0001", in_ready);
    end
    advance();                               // pointer now 1
    in_valid = 4'b1001;
    #1;
    n_checks++;
    if (in_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL sparse_ch3: got %b want 1000", in_ready);
    end
    advance();
    n_checks++;
    if (out_sel !== 2'd3 || m_ptr !== 0) begin
      n_fail++;
      $display("FAIL sparse_wrap: got s=%0d model_ptr=%0d want s=3 ptr=0", out_sel, m_ptr);
    end
    $display("test_sparse_rr: out_sel=%0d", out_sel);
  endtask

  task automatic test_reset_mid();
    mode = 1; out_ready = 1; in_data = $urandom;
    in_valid = 4'b0100;                      // ch2 -> pointer moves to 3
    #1;
    advance();
    out_ready = 0; rst = 1; in_valid = 4'b1111;
    #1;
    n_checks++;
    if (in_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_in_ready: got %b want 0000", in_ready);
    end
    advance();
    rst = 0; out_ready = 1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_beat_lost: got v=%b want 0", out_valid);
    end
    #1;
    n_checks++;
    if (in_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got %b want 0001", in_ready);
    end
    advance();
    $display("test_reset_mid: restart out_sel=%0d", out_sel);
  endtask

  task automatic test_random();
    logic [7:0] sb[$];
    int p;
    in_valid = 0; out_ready = 1;
    #1;
    advance();                               // empty the buffer
    for (int i = 0; i < 300; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (in_ready !== model_ready() || $countones(in_ready) > 1) begin
        n_fail++;
        $display("FAIL rand_in_ready %0d: got %b want %b", i, in_ready, model_ready());
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rand_dup %0d: got d=%h want no beat", i, out_data);
        end else begin
          logic [7:0] e = sb.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL rand_order %0d: got d=%h want %h", i, out_data, e);
          end
        end
      end
      p = model_pick();
      if (p >= 0) sb.push_back(in_data[p*8 +: 8]);
      advance();
      n_checks++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_sel !== 2'(m_sel)))) begin
        n_fail++;
        $display("FAIL rand_out %0d: got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                 i, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
      end
    end
    n_checks++;
    if (sb.size() != (m_valid ? 1 : 0)) begin
      n_fail++;
      $display("FAIL rand_drop: got %0d pending want %0d", sb.size(), m_valid ? 1 : 0);
    end
    $display("test_random: 300 cycles, %0d pending", sb.size());
  endtask

  initial begin
    rst = 1; mode = 0; sel = 0; in_valid = 0; in_data = 0; out_ready = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_sparse_rr();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
